// File: rtl/actuador_puertas_pkg.sv
// Door actuator shared encodings: status word and command word, common with the door controller.
package actuador_puertas_pkg;

    typedef enum logic [1:0] {
        PT_CERRADA  = 2'b00,
        PT_ABIERTA  = 2'b01,
        PT_CERRANDO = 2'b10,
        PT_ABRIENDO = 2'b11
    } estado_t;

    localparam logic [1:0] CMD_NADA   = 2'b00;
    localparam logic [1:0] CMD_ABRIR  = 2'b01;
    localparam logic [1:0] CMD_CERRAR = 2'b10;

endpackage

// File: rtl/actuador_puertas_temporizador.sv
// Saturating up-counter with sync clear and enable; lleno_o is registered and high while count==LIMIT.
// Latency: lleno_o follows the count on the same edge; no backpressure (free-running when enabled).
module temporizador_puertas #(
    parameter int LIMIT = 50,
    parameter int W     = $clog2(LIMIT + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         lleno_o
);

    localparam logic [W-1:0] LIM = W'(LIMIT);

    logic [W-1:0] cnt_q, cnt_d;
    logic         lleno_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LIM)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            lleno_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            lleno_q <= (cnt_d == LIM);
        end
    end

    assign cnt_o   = cnt_q;
    assign lleno_o = lleno_q;

endmodule

// File: rtl/actuador_puertas.sv
// Door leaf actuator: runs travel, dwell and reopen bookkeeping from the controller's command bus.
// All outputs registered (one edge from command); no backpressure, commands are sampled every cycle.
module actuador_puertas
    import actuador_puertas_pkg::*;
#(
    parameter int T_TRAVEL   = 8,
    parameter int T_DWELL    = 50,
    parameter int MAX_REOPEN = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [1:0]                    salida_puertas,
    input  logic                          sensor,
    output logic [1:0]                    puertas,
    output logic                          timeout,
    output logic                          cerrada,
    output logic                          obstruccion,
    output logic [$clog2(T_TRAVEL+1)-1:0] posicion
);

    localparam int PW = $clog2(T_TRAVEL + 1);
    localparam int RW = $clog2(MAX_REOPEN + 1);
    localparam int DW = $clog2(T_DWELL + 1);
    localparam logic [PW-1:0] POS_MAX = PW'(T_TRAVEL);
    localparam logic [RW-1:0] REO_MAX = RW'(MAX_REOPEN);

    estado_t       state_q, state_d;
    logic [PW-1:0] pos_q, pos_d;
    logic [RW-1:0] reopen_q, reopen_d;
    logic          cerrada_q, obs_q;
    logic          dwell_clr;
    logic [DW-1:0] dwell_cnt;
    logic          dwell_lleno;

    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        reopen_d = reopen_q;
        case (state_q)
            PT_CERRADA: begin
                if (salida_puertas == CMD_ABRIR) state_d = PT_ABRIENDO;
            end
            PT_ABRIENDO: begin
                // A reversal freezes the leaf for one edge before it starts moving back.
                if (salida_puertas == CMD_CERRAR) begin
                    state_d = PT_CERRANDO;
                end else if (pos_q >= POS_MAX - PW'(1)) begin
                    state_d = PT_ABIERTA;
                    pos_d   = POS_MAX;
                end else begin
                    pos_d = pos_q + PW'(1);
                end
            end
            PT_ABIERTA: begin
                if ((salida_puertas == CMD_CERRAR) && !sensor) state_d = PT_CERRANDO;
            end
            PT_CERRANDO: begin
                if (sensor) begin
                    state_d = PT_ABRIENDO;
                    if (reopen_q != REO_MAX) reopen_d = reopen_q + RW'(1);
                end else if (salida_puertas == CMD_ABRIR) begin
                    state_d = PT_ABRIENDO;
                end else if (pos_q <= PW'(1)) begin
                    state_d = PT_CERRADA;
                    pos_d   = '0;
                end else begin
                    pos_d = pos_q - PW'(1);
                end
            end
            default: state_d = PT_CERRADA;
        endcase
        if (state_d == PT_CERRADA) reopen_d = '0;
    end

    // Dwell only accumulates across consecutive OPEN cycles with no activity.
    assign dwell_clr = (state_q != PT_ABIERTA) || (state_d != PT_ABIERTA) ||
                       sensor || (salida_puertas == CMD_ABRIR);

    temporizador_puertas #(
        .LIMIT (T_DWELL),
        .W     (DW)
    ) u_dwell (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (dwell_clr),
        .en_i    (1'b1),
        .cnt_o   (dwell_cnt),
        .lleno_o (dwell_lleno)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= PT_CERRADA;
            pos_q     <= '0;
            reopen_q  <= '0;
            cerrada_q <= 1'b1;
            obs_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            reopen_q  <= reopen_d;
            cerrada_q <= (state_d == PT_CERRADA);
            obs_q     <= (reopen_d == REO_MAX);
        end
    end

    assign puertas     = state_q;
    assign posicion    = pos_q;
    assign cerrada     = cerrada_q;
    assign obstruccion = obs_q;
    assign timeout     = dwell_lleno;

    logic unused_dwell;
    assign unused_dwell = ^dwell_cnt;

endmodule

// File: tb/tb_actuador_puertas.sv
// Scoreboard bench for actuador_puertas with T_TRAVEL=4, T_DWELL=6, MAX_REOPEN=2.
module tb_actuador_puertas;

    typedef struct packed {
        logic [1:0] st;
        logic [2:0] pos;
        logic       to;
        logic       cer;
        logic       obs;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] salida_puertas;
    logic       sensor;
    logic [1:0] puertas;
    logic       timeout, cerrada, obstruccion;
    logic [2:0] posicion;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   nchk  = 0;

    localparam logic [1:0] C = 2'b00, O = 2'b01, CL = 2'b10, OP = 2'b11;
    localparam logic [1:0] NA = 2'b00, AB = 2'b01, CE = 2'b10, X3 = 2'b11;

    actuador_puertas #(.T_TRAVEL(4), .T_DWELL(6), .MAX_REOPEN(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .salida_puertas (salida_puertas),
        .sensor         (sensor),
        .puertas        (puertas),
        .timeout        (timeout),
        .cerrada        (cerrada),
        .obstruccion    (obstruccion),
        .posicion       (posicion)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic cmp(input string name, input logic [3:0] act, input logic [3:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s check#%0d t=%0t: actual=%0h required=%0h", name, nchk, $time, act, req);
        end
    endtask

    // Monitor: every clock edge or asynchronous reset drop, the oldest expectation is checked.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or negedge rst_n);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                nchk++;
                cmp("puertas",     {2'b00, puertas},     {2'b00, e.st});
                cmp("posicion",    {1'b0, posicion},     {1'b0, e.pos});
                cmp("timeout",     {3'b000, timeout},    {3'b000, e.to});
                cmp("cerrada",     {3'b000, cerrada},    {3'b000, e.cer});
                cmp("obstruccion", {3'b000, obstruccion},{3'b000, e.obs});
            end
        end
    end

    function automatic exp_t mk(input logic [1:0] st, input int p, input logic to, input logic ob);
        exp_t e;
        e.st  = st;
        e.pos = p[2:0];
        e.to  = to;
        e.cer = (st == C);
        e.obs = ob;
        return e;
    endfunction

    task automatic step(input logic [1:0] c, input logic s, input logic [1:0] st,
                        input int p, input logic to, input logic ob);
        @(negedge clk);
        salida_puertas = c;
        sensor         = s;
        q.push_back(mk(st, p, to, ob));
    endtask

    task automatic open_full();
        step(AB, 0, OP, 0, 0, 0);
        step(NA, 0, OP, 1, 0, 0);
        step(NA, 0, OP, 2, 0, 0);
        step(NA, 0, OP, 3, 0, 0);
        step(NA, 0, O,  4, 0, 0);
    endtask

    initial begin
        rst_n          = 1'b0;
        salida_puertas = NA;
        sensor         = 1'b0;

        step(NA, 0, C, 0, 0, 0);
        step(AB, 1, C, 0, 0, 0);
        @(negedge clk);
        salida_puertas = NA;
        sensor         = 1'b0;
        rst_n          = 1'b1;

        // full opening stroke
        open_full();

        // dwell: timeout on 6th edge, saturates, cleared by open command then by sensor
        for (int i = 1; i <= 5; i++) step(NA, 0, O, 4, 0, 0);
        step(NA, 0, O, 4, 1, 0);
        step(NA, 0, O, 4, 1, 0);
        step(AB, 0, O, 4, 0, 0);
        step(NA, 0, O, 4, 0, 0);
        step(NA, 0, O, 4, 0, 0);
        step(NA, 1, O, 4, 0, 0);
        for (int i = 1; i <= 5; i++) step(NA, 0, O, 4, 0, 0);
        step(NA, 0, O, 4, 1, 0);

        // close blocked by sensor, then full close; cmd 11 holds in CLOSED
        step(CE, 1, O,  4, 0, 0);
        step(CE, 0, CL, 4, 0, 0);
        step(NA, 0, CL, 3, 0, 0);
        step(NA, 0, CL, 2, 0, 0);
        step(NA, 0, CL, 1, 0, 0);
        step(NA, 0, C,  0, 0, 0);
        step(X3, 0, C,  0, 0, 0);

        // sensor reopens: second one raises obstruccion, saturates, clears on CLOSED
        open_full();
        step(CE, 0, CL, 4, 0, 0);
        step(NA, 0, CL, 3, 0, 0);
        step(NA, 0, CL, 2, 0, 0);
        step(NA, 1, OP, 2, 0, 0);
        step(NA, 0, OP, 3, 0, 0);
        step(NA, 0, O,  4, 0, 0);
        step(CE, 0, CL, 4, 0, 0);
        step(NA, 0, CL, 3, 0, 0);
        step(NA, 1, OP, 3, 0, 1);
        step(NA, 0, O,  4, 0, 1);
        step(CE, 0, CL, 4, 0, 1);
        step(NA, 1, OP, 4, 0, 1);
        step(NA, 0, O,  4, 0, 1);
        step(CE, 0, CL, 4, 0, 1);
        step(NA, 0, CL, 3, 0, 1);
        step(NA, 0, CL, 2, 0, 1);
        step(NA, 0, CL, 1, 0, 1);
        step(NA, 0, C,  0, 0, 0);

        // open-command reversal does not count as a reopen
        open_full();
        step(CE, 0, CL, 4, 0, 0);
        step(NA, 0, CL, 3, 0, 0);
        step(AB, 0, OP, 3, 0, 0);
        step(NA, 0, O,  4, 0, 0);
        step(CE, 0, CL, 4, 0, 0);
        step(NA, 1, OP, 4, 0, 0);
        step(NA, 0, O,  4, 0, 0);
        step(CE, 0, CL, 4, 0, 0);
        step(NA, 0, CL, 3, 0, 0);
        step(NA, 1, OP, 3, 0, 1);
        step(NA, 0, O,  4, 0, 1);
        step(CE, 0, CL, 4, 0, 1);
        step(NA, 0, CL, 3, 0, 1);
        step(NA, 0, CL, 2, 0, 1);
        step(NA, 0, CL, 1, 0, 1);
        step(NA, 0, C,  0, 0, 0);

        // reversal during opening, cmd 11 acting as hold while moving
        step(AB, 0, OP, 0, 0, 0);
        step(X3, 0, OP, 1, 0, 0);
        step(X3, 0, OP, 2, 0, 0);
        step(CE, 0, CL, 2, 0, 0);
        step(X3, 0, CL, 1, 0, 0);
        step(X3, 0, C,  0, 0, 0);

        // asynchronous reset mid-close
        open_full();
        step(CE, 0, CL, 4, 0, 0);
        step(NA, 0, CL, 3, 0, 0);
        step(NA, 0, CL, 2, 0, 0);
        @(posedge clk);
        #3;
        q.push_back(mk(C, 0, 0, 0));
        rst_n = 1'b0;
        step(NA, 0, C, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(AB, 0, OP, 0, 0, 0);
        step(NA, 0, OP, 1, 0, 0);

        repeat (3) @(posedge clk);
        #2;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: actual=%0d pending required=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
